// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM states and counter sizing.
package ccff_loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_e;

  // Width of a counter that must be able to hold the value chain_len itself.
  function automatic int bit_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for ccff_tail readback: first captured bit lands in the MSB,
// a flush left-aligns and zero-pads a partial word. Held until accepted.
module ccff_rb_packer #(
  parameter int WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bit,
  input  logic              i_shift,
  input  logic              i_flush,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_pending
);
  localparam int FW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sr;
  logic [WORD_W-1:0] r_data;
  logic [FW-1:0]     r_fill;
  logic              r_valid;
  logic [WORD_W-1:0] w_sr_nxt;

  assign w_sr_nxt  = (r_sr << 1) | WORD_W'(i_bit);
  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_pending = (r_fill != '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sr    <= '0;
      r_data  <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
    end else begin
      // Acceptance first so a word completing on the same edge re-asserts valid.
      if (r_valid && i_ready) r_valid <= 1'b0;
      if (i_shift) begin
        r_sr <= w_sr_nxt;
        if (r_fill == FW'(WORD_W - 1)) begin
          r_data  <= w_sr_nxt;
          r_valid <= 1'b1;
          r_fill  <= '0;
        end else begin
          r_fill <= r_fill + FW'(1);
        end
      end else if (i_flush) begin
        r_data  <= r_sr << (FW'(WORD_W) - r_fill);
        r_valid <= 1'b1;
        r_fill  <= '0;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Drives a ccff configuration chain MSB-first from cfg words, gates prog_clk via
// prog_clk_en, and returns the displaced chain contents as readback words.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 5,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done
);
  import ccff_loader_pkg::*;

  localparam int CW = bit_cnt_w(CHAIN_LEN);
  localparam int BW = $clog2(WORD_W + 1);

  state_e            r_state, w_next;
  logic [CW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_buf;
  logic [BW-1:0]     r_bits;

  logic              w_shift, w_last_shift, w_need, w_take, w_flush;
  logic              w_rb_valid, w_rb_pending;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     w_load_bits;
  int                w_remain;

  assign w_shift      = (r_state == LOAD) && (r_bits != '0) && !(w_rb_valid && !rb_ready)
                        && (r_bit_cnt < CW'(CHAIN_LEN));
  assign w_last_shift = w_shift && (r_bit_cnt == CW'(CHAIN_LEN - 1));
  // More bits still have to be fetched beyond what is counted or buffered.
  assign w_need       = (int'(r_bit_cnt) + int'(r_bits)) < CHAIN_LEN;
  assign w_take       = cfg_valid && cfg_ready;
  assign w_flush      = (r_state == FLUSH) && w_rb_pending && !w_rb_valid;
  assign w_cnt_nxt    = r_bit_cnt + CW'(w_shift);
  assign ccff_head    = r_buf[WORD_W-1];
  assign prog_clk_en  = w_shift;
  assign rb_valid     = w_rb_valid;

  // A word loaded near the end only contributes the bits the chain still needs.
  always_comb begin
    w_remain    = CHAIN_LEN - int'(w_cnt_nxt);
    w_load_bits = (w_remain > WORD_W) ? BW'(WORD_W) : BW'(w_remain);
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      r_bit_cnt <= '0;
      r_buf     <= '0;
      r_bits    <= '0;
    end else if (r_state == IDLE) begin
      r_bit_cnt <= '0;
      r_bits    <= '0;
    end else begin
      if (w_shift) r_bit_cnt <= r_bit_cnt + CW'(1);
      if (w_take) begin
        r_buf  <= cfg_data;
        r_bits <= w_load_bits;
      end else if (w_shift) begin
        r_buf  <= r_buf << 1;
        r_bits <= r_bits - BW'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD;
      LOAD:    if (w_last_shift) w_next = FLUSH;
      FLUSH:   if (w_rb_valid ? rb_ready : !w_rb_pending) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == LOAD);
    done      = (r_state == DONE);
    cfg_ready = (r_state == LOAD) && w_need
                && ((r_bits == '0) || ((r_bits == BW'(1)) && w_shift));
  end

  ccff_rb_packer #(.WORD_W(WORD_W)) u_rb (
    .i_clk     (prog_clk),
    .i_rst_n   (prog_rst_n),
    .i_bit     (ccff_tail),
    .i_shift   (w_shift),
    .i_flush   (w_flush),
    .i_ready   (rb_ready),
    .o_data    (rb_data),
    .o_valid   (w_rb_valid),
    .o_pending (w_rb_pending)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench: two loaders (5-bit and 40-bit chains) driving behavioural chain models.
module tb_ccff_chain_loader;
  logic prog_clk = 1'b0;
  logic prog_rst_n;
  always #5 prog_clk = ~prog_clk;

  logic        start5, cfg_valid5, cfg_ready5, head5, tail5, en5, rb_valid5, rb_ready5, busy5, done5;
  logic [31:0] cfg_data5, rb_data5;
  logic        start40, cfg_valid40, cfg_ready40, head40, tail40, en40, rb_valid40, rb_ready40, busy40, done40;
  logic [31:0] cfg_data40, rb_data40;

  ccff_chain_loader #(.CHAIN_LEN(5), .WORD_W(32)) u_dut5 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start5), .cfg_data(cfg_data5),
    .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5), .ccff_head(head5), .ccff_tail(tail5),
    .prog_clk_en(en5), .rb_data(rb_data5), .rb_valid(rb_valid5), .rb_ready(rb_ready5),
    .busy(busy5), .done(done5));

  ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_dut40 (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start40), .cfg_data(cfg_data40),
    .cfg_valid(cfg_valid40), .cfg_ready(cfg_ready40), .ccff_head(head40), .ccff_tail(tail40),
    .prog_clk_en(en40), .rb_data(rb_data40), .rb_valid(rb_valid40), .rb_ready(rb_ready40),
    .busy(busy40), .done(done40));

  // Downstream chain models; tail is the far end of the chain.
  logic [4:0]  chain5,  pre5_val;
  logic [39:0] chain40, pre40_val;
  logic        pre5_go = 1'b0, pre40_go = 1'b0;
  assign tail5  = chain5[4];
  assign tail40 = chain40[39];
  always @(posedge prog_clk) begin
    if (pre5_go)  chain5  <= pre5_val;  else if (en5)  chain5  <= {chain5[3:0], head5};
    if (pre40_go) chain40 <= pre40_val; else if (en40) chain40 <= {chain40[38:0], head40};
  end

  int checks = 0, failures = 0;
  int en_cnt5 = 0, stall5 = 0, done_cnt5 = 0, en_cnt40 = 0, stall40 = 0, done_cnt40 = 0;
  bit          exp_head5[$], exp_head40[$];
  logic [31:0] exp_rb5[$],   exp_rb40[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge prog_clk); #1;
  endtask

  // Monitor: pops expected head bits on every enabled edge and words on every rb handshake.
  always @(negedge prog_clk) begin
    if (prog_rst_n === 1'b1 || en5 === 1'b1 || en40 === 1'b1) begin
      if (en5 === 1'b1) begin
        en_cnt5++;
        if (exp_head5.size() == 0) chk("head5_unexpected", {63'd0, head5}, 64'hx);
        else chk("head5", {63'd0, head5}, {63'd0, exp_head5.pop_front()});
      end
      if (en40 === 1'b1) begin
        en_cnt40++;
        if (exp_head40.size() == 0) chk("head40_unexpected", {63'd0, head40}, 64'hx);
        else chk("head40", {63'd0, head40}, {63'd0, exp_head40.pop_front()});
      end
      if (busy5 === 1'b1 && en5 !== 1'b1)   stall5++;
      if (busy40 === 1'b1 && en40 !== 1'b1) stall40++;
      if (rb_valid5 === 1'b1 && rb_ready5 === 1'b1) begin
        if (exp_rb5.size() == 0) chk("rb5_unexpected", {32'd0, rb_data5}, 64'hx);
        else chk("rb5", {32'd0, rb_data5}, {32'd0, exp_rb5.pop_front()});
      end
      if (rb_valid40 === 1'b1 && rb_ready40 === 1'b1) begin
        if (exp_rb40.size() == 0) chk("rb40_unexpected", {32'd0, rb_data40}, 64'hx);
        else chk("rb40", {32'd0, rb_data40}, {32'd0, exp_rb40.pop_front()});
      end
      if (done5 === 1'b1)  done_cnt5++;
      if (done40 === 1'b1) done_cnt40++;
    end
  end

  task automatic preload5(input logic [4:0] v);
    pre5_val = v; pre5_go = 1'b1; tick; pre5_go = 1'b0;
  endtask

  task automatic preload40(input logic [39:0] v);
    pre40_val = v; pre40_go = 1'b1; tick; pre40_go = 1'b0;
  endtask

  task automatic push5(input logic [31:0] w);
    for (int i = 0; i < 5; i++) exp_head5.push_back(w[31-i]);
  endtask

  task automatic push40(input logic [31:0] w0, input logic [31:0] w1);
    for (int i = 0; i < 32; i++) exp_head40.push_back(w0[31-i]);
    for (int i = 0; i < 8; i++)  exp_head40.push_back(w1[31-i]);
  endtask

  task automatic run5(input logic [31:0] w, input bit poke, input int exp_lat);
    int lat; bit got; bit acc;
    lat = 0; got = 1'b0; acc = 1'b0;
    start5 = 1'b1; tick; start5 = 1'b0;
    fork
      begin
        cfg_data5 = w; cfg_valid5 = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
          @(negedge prog_clk); acc = cfg_ready5; @(posedge prog_clk); #1;
        end
        cfg_valid5 = 1'b0;
        if (!acc) chk("cfg5_accept_timeout", 64'd0, 64'd1);
      end
      begin
        for (int k = 0; k < 100; k++) begin
          tick; lat++;
          start5 = poke && (lat == 2);
          if (done5) begin got = 1'b1; break; end
        end
      end
    join
    if (!got) chk("done5_timeout", 64'd0, 64'd1);
    chk("lat5", lat, exp_lat);
    start5 = poke;
    tick; start5 = 1'b0;
    chk("done5_one_cycle", {63'd0, done5}, 64'd0);
    repeat (3) tick;
    chk("busy5_after_done", {63'd0, busy5}, 64'd0);
  endtask

  task automatic run40(input logic [31:0] w0, input logic [31:0] w1, input int pre_delay,
                       input bit rbstall, input int exp_lat);
    int lat; bit got;
    lat = 0; got = 1'b0;
    rb_ready40 = !rbstall;
    start40 = 1'b1; tick; start40 = 1'b0;
    fork
      begin
        for (int i = 0; i < 2; i++) begin
          bit acc, seen;
          acc = 1'b0; seen = 1'b0;
          if (i == 0 && pre_delay > 0) begin
            for (int k = 0; k < 20 && !seen; k++) begin @(negedge prog_clk); seen = cfg_ready40; end
            repeat (pre_delay) tick;
          end
          cfg_data40 = (i == 0) ? w0 : w1; cfg_valid40 = 1'b1;
          for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge prog_clk); acc = cfg_ready40; @(posedge prog_clk); #1;
          end
          cfg_valid40 = 1'b0;
          if (!acc) chk("cfg40_accept_timeout", i, 64'hff);
        end
      end
      begin
        if (rbstall) begin
          bit seen;
          seen = 1'b0;
          for (int k = 0; k < 100 && !seen; k++) begin @(negedge prog_clk); seen = rb_valid40; end
          repeat (4) tick;
          rb_ready40 = 1'b1;
        end
      end
      begin
        for (int k = 0; k < 300; k++) begin
          tick; lat++;
          if (done40) begin got = 1'b1; break; end
        end
      end
    join
    if (!got) chk("done40_timeout", 64'd0, 64'd1);
    chk("lat40", lat, exp_lat);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n; bit hs; int e0, s0;
    prog_rst_n = 1'b0;
    start5 = 0; cfg_valid5 = 0; cfg_data5 = '0; rb_ready5 = 1'b1;
    start40 = 0; cfg_valid40 = 0; cfg_data40 = '0; rb_ready40 = 1'b1;
    preload5(5'b00000);
    preload40(40'd0);
    tick;
    chk("rst5_outs",  {busy5, done5, cfg_ready5, head5, en5, rb_valid5, rb_data5}, 64'd0);
    chk("rst40_outs", {busy40, done40, cfg_ready40, head40, en40, rb_valid40, rb_data40}, 64'd0);
    prog_rst_n = 1'b1; tick;

    // cfg_valid while idle is held off
    cfg_data5 = 32'hFFFF_FFFF; cfg_valid5 = 1'b1;
    repeat (2) tick;
    chk("idle_cfg_ready", {62'd0, cfg_ready5, busy5}, 64'd0);
    cfg_valid5 = 1'b0;

    // Basic load + readback
    preload5(5'b10011);
    push5(32'hA800_0000); exp_rb5.push_back(32'h9800_0000);
    e0 = en_cnt5; s0 = stall5;
    run5(32'hA800_0000, 1'b0, 8);
    chk("chain5_t1", chain5, 5'b10101);
    chk("en5_t1", en_cnt5 - e0, 5);
    chk("stall5_t1", stall5 - s0, 1);

    // Reset mid-load after two shifts
    preload5(5'b01100);
    push5(32'hF000_0000);
    start5 = 1'b1; tick; start5 = 1'b0;
    cfg_data5 = 32'hF000_0000; cfg_valid5 = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      hs = cfg_valid5 && cfg_ready5;
      if (en5) n++;
      if (n == 2) break;
      tick;
      if (hs) cfg_valid5 = 1'b0;
    end
    chk("rst_mid_shifts_seen", n, 2);
    prog_rst_n = 1'b0; cfg_valid5 = 1'b0;
    tick;
    chk("rst_mid_outs", {busy5, done5, cfg_ready5, head5, en5, rb_valid5, rb_data5}, 64'd0);
    prog_rst_n = 1'b1;
    chk("rst_mid_heads_used", exp_head5.size(), 3);
    exp_head5.delete();
    tick;
    chk("chain5_partial", chain5, 5'b10011);

    // Clean load following the aborted one
    push5(32'h5000_0000); exp_rb5.push_back(32'h9800_0000);
    run5(32'h5000_0000, 1'b0, 8);
    chk("chain5_t2", chain5, 5'b01010);
    chk("done5_count_t2", done_cnt5, 2);

    // start pulses during LOAD and DONE are ignored
    push5(32'h3800_0000); exp_rb5.push_back(32'h5000_0000);
    e0 = en_cnt5;
    run5(32'h3800_0000, 1'b1, 8);
    chk("chain5_t3", chain5, 5'b00111);
    chk("en5_t3", en_cnt5 - e0, 5);
    chk("done5_count_t3", done_cnt5, 3);

    // Multi-word, no stalls
    preload40(40'hDE_ADBE_EF5A);
    push40(32'hFFFF_0000, 32'hC300_0000);
    exp_rb40.push_back(32'hDEAD_BEEF); exp_rb40.push_back(32'h5A00_0000);
    e0 = en_cnt40; s0 = stall40;
    run40(32'hFFFF_0000, 32'hC300_0000, 0, 1'b0, 43);
    chk("chain40_r1", chain40, 40'hFF_FF00_00C3);
    chk("en40_r1", en_cnt40 - e0, 40);
    chk("stall40_r1", stall40 - s0, 1);

    // cfg_valid held off 3 cycles, then rb_ready low 4 cycles on the first word
    preload40(40'h01_2345_6789);
    push40(32'h1234_5678, 32'h9A00_0000);
    exp_rb40.push_back(32'h0123_4567); exp_rb40.push_back(32'h8900_0000);
    e0 = en_cnt40; s0 = stall40;
    run40(32'h1234_5678, 32'h9A00_0000, 3, 1'b1, 50);
    chk("chain40_r2", chain40, 40'h12_3456_789A);
    chk("en40_r2", en_cnt40 - e0, 40);
    chk("stall40_r2", stall40 - s0, 8);
    chk("done40_count", done_cnt40, 2);

    repeat (3) tick;
    chk("head5_left",  exp_head5.size(),  0);
    chk("head40_left", exp_head40.size(), 0);
    chk("rb5_left",    exp_rb5.size(),    0);
    chk("rb40_left",   exp_rb40.size(),   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
